// File: rtl/gpu_cmd_queue_pkg.sv
// -----------------------------------------------------------------------------
// gpu_cmd_pkg
// Shared definitions for the GPU draw-command queue. It holds the command
// geometry, the register indices that the gpu_control register slave writes,
// the bit positions of the status readback word, and the default command type.
// -----------------------------------------------------------------------------
package gpu_cmd_pkg;

  localparam int CMD_WORDS  = 4;
  localparam int CMD_DATA_W = 32;

  // Slave register indices. Indices 0..2 are staging words; index 3 commits.
  localparam logic [1:0] IDX_W0     = 2'd0;
  localparam logic [1:0] IDX_W1     = 2'd1;
  localparam logic [1:0] IDX_W2     = 2'd2;
  localparam logic [1:0] IDX_COMMIT = 2'd3;

  // Status word layout.
  localparam int ST_LVL_LSB  = 0;
  localparam int ST_LVL_W    = 5;
  localparam int ST_OVF      = 8;
  localparam int ST_BUSY     = 9;
  localparam int ST_IRQ      = 10;
  localparam int ST_DONE_LSB = 16;
  localparam int ST_DONE_W   = 16;

  // One draw command: word0 sits in the low bits, word3 in the top bits.
  typedef logic [CMD_WORDS-1:0][CMD_DATA_W-1:0] cmd_t;

endpackage

// File: rtl/gpu_cmd_queue_if.sv
// -----------------------------------------------------------------------------
// gpu_cmd_if
// Command handshake from the queue to the rasterizer.
//   cmd_valid : command available          (master -> slave)
//   cmd_data  : command, word0 in low bits (master -> slave)
//   cmd_ready : rasterizer accepts         (slave  -> master)
// -----------------------------------------------------------------------------
interface gpu_cmd_if #(
  parameter int DATA_W = 32
) ();
  import gpu_cmd_pkg::*;

  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [CMD_WORDS*DATA_W-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/gpu_cmd_queue_fifo.sv
// -----------------------------------------------------------------------------
// gpu_cmd_fifo
// Synchronous FIFO of DEPTH commands. The head is held in its own register.
// A push and a pop may occur together even when the FIFO is full.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   push_i       : write push_data_i (ignored if full without a pop)
//   push_data_i  : command to enqueue
//   pop_i        : drop the head (ignored if empty)
//   full_o       : level == DEPTH
//   empty_o      : level == 0
//   level_o      : occupancy 0..DEPTH
//   head_o       : registered head entry
// -----------------------------------------------------------------------------
module gpu_cmd_fifo
  import gpu_cmd_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = cmd_t,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  T                 push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o,
  output T                 head_o
);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  T                 head_q, head_d;
  logic             push, pop;

  assign pop  = pop_i & (level_q != '0);
  assign push = push_i & ((level_q != LVL_W'(DEPTH)) | pop);

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    head_d  = head_q;
    // The new entry becomes the head when the FIFO is, or is about to be, empty.
    if (push && (level_q == '0 || (pop && level_q == LVL_W'(1)))) begin
      head_d = push_data_i;
    end else if (pop && level_q > LVL_W'(1)) begin
      head_d = mem_q[rd_ptr_q + PTR_W'(1)];
    end
  end

  // NOTE: sequential state is updated with non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
      head_q  <= head_d;
    end
  end

  // NOTE: the storage array has no reset; it is only read behind the level count, so reset would be wasted.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = head_q;

endmodule

// File: rtl/gpu_cmd_queue.sv
// -----------------------------------------------------------------------------
// gpu_cmd_queue
// Turns register-slave writes into atomic 4-word draw commands, queues them,
// issues them to the rasterizer, and reports progress in a status word.
// Optional interrupt: define GPU_CMD_QUEUE_IRQ_EN to raise irq when all work
// drains; otherwise irq and status[10] are tied 0.
// Ports:
//   ACLK, ARESET  : clock, asynchronous active-high reset
//   reg_wr_en     : register write completed this cycle
//   reg_wr_idx    : index written (0..2 stage, 3 commit)
//   reg_wr_data   : data written
//   status_clr    : clears sticky overflow and irq pending
//   done_pulse    : rasterizer finished one command
//   cmd           : command handshake to the rasterizer (master side)
//   status        : registered status word for readback
//   irq           : level interrupt
// -----------------------------------------------------------------------------
module gpu_cmd_queue
  import gpu_cmd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              reg_wr_en,
  input  logic [1:0]        reg_wr_idx,
  input  logic [DATA_W-1:0] reg_wr_data,
  input  logic              status_clr,
  input  logic              done_pulse,
  gpu_cmd_if.master         cmd,
  output logic [31:0]       status,
  output logic              irq
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int OUT_W = $clog2(DEPTH) + 5;

  typedef logic [CMD_WORDS-1:0][DATA_W-1:0] cmd_w_t;

  logic [2:0][DATA_W-1:0] stg_q;
  logic [OUT_W-1:0]       out_q, out_d;
  logic [CNT_W-1:0]       done_cnt_q, done_cnt_d;
  logic                   ovf_q, ovf_d;
  logic [31:0]            status_q, status_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   fifo_full, fifo_empty;
  logic                   commit, hs, push, done_ok, busy_d;
  cmd_w_t                 head;
`ifdef GPU_CMD_QUEUE_IRQ_EN
  logic                   irq_q, irq_d;
`endif

  assign commit = reg_wr_en & (reg_wr_idx == IDX_COMMIT);
  assign hs     = cmd.cmd_valid & cmd.cmd_ready;
  // A full FIFO still accepts a commit when the head leaves in the same cycle.
  assign push   = commit & (~fifo_full | hs);

  gpu_cmd_fifo #(.DEPTH(DEPTH), .T(cmd_w_t)) u_fifo (
    .clk         (ACLK),
    .rst         (ARESET),
    .push_i      (push),
    .push_data_i ({reg_wr_data, stg_q[2], stg_q[1], stg_q[0]}),
    .pop_i       (hs),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level_q),
    .head_o      (head)
  );

  assign cmd.cmd_valid = ~fifo_empty;
  assign cmd.cmd_data  = head;

  always_comb begin
    level_d = level_q + LVL_W'(push) - LVL_W'(hs);
    // A done with nothing outstanding and no issue this cycle is spurious.
    done_ok = done_pulse & (hs | (out_q != '0));
    out_d   = out_q;
    if (hs && !done_pulse)      out_d = out_q + OUT_W'(1);
    else if (done_ok && !hs)    out_d = out_q - OUT_W'(1);
    done_cnt_d = done_cnt_q + CNT_W'(done_ok);
    busy_d     = (level_d != '0) | (out_d != '0);
    ovf_d      = (commit & fifo_full & ~hs) | (ovf_q & ~status_clr);
`ifdef GPU_CMD_QUEUE_IRQ_EN
    // status_q still holds last cycle's busy, which gives the falling edge.
    irq_d = (status_q[ST_BUSY] & ~busy_d) | (irq_q & ~status_clr);
`endif
    status_d = '0;
    status_d[ST_LVL_LSB +: ST_LVL_W]   = ST_LVL_W'(level_d);
    status_d[ST_OVF]                   = ovf_d;
    status_d[ST_BUSY]                  = busy_d;
    status_d[ST_DONE_LSB +: ST_DONE_W] = ST_DONE_W'(done_cnt_d);
`ifdef GPU_CMD_QUEUE_IRQ_EN
    status_d[ST_IRQ]                   = irq_d;
`endif
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      stg_q      <= '0;
      out_q      <= '0;
      done_cnt_q <= '0;
      ovf_q      <= 1'b0;
      status_q   <= '0;
`ifdef GPU_CMD_QUEUE_IRQ_EN
      irq_q      <= 1'b0;
`endif
    end else begin
      if (reg_wr_en) begin
        case (reg_wr_idx)
          IDX_W0:  stg_q[0] <= reg_wr_data;
          IDX_W1:  stg_q[1] <= reg_wr_data;
          IDX_W2:  stg_q[2] <= reg_wr_data;
          default: ;
        endcase
      end
      out_q      <= out_d;
      done_cnt_q <= done_cnt_d;
      ovf_q      <= ovf_d;
      status_q   <= status_d;
`ifdef GPU_CMD_QUEUE_IRQ_EN
      irq_q      <= irq_d;
`endif
    end
  end

  assign status = status_q;
`ifdef GPU_CMD_QUEUE_IRQ_EN
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// -----------------------------------------------------------------------------
// tb_gpu_cmd_queue
// Directed bench for gpu_cmd_queue. Inputs change on the falling edge and
// outputs are sampled on the falling edge after each rising edge.
// Expected status words are hand-computed from the documented layout.
// -----------------------------------------------------------------------------
module tb_gpu_cmd_queue;
  import gpu_cmd_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        reg_wr_en;
  logic [1:0]  reg_wr_idx;
  logic [31:0] reg_wr_data;
  logic        status_clr;
  logic        done_pulse;
  logic [31:0] status;
  logic        irq;

  int errors = 0;
  int checks = 0;

`ifdef GPU_CMD_QUEUE_IRQ_EN
  localparam logic [31:0] IRQ_ST = 32'h0000_0400;
  localparam logic        IRQ_ON = 1'b1;
`else
  localparam logic [31:0] IRQ_ST = 32'h0000_0000;
  localparam logic        IRQ_ON = 1'b0;
`endif

  gpu_cmd_if #(.DATA_W(32)) cmd_bus ();

  gpu_cmd_queue #(.DATA_W(32), .DEPTH(4), .CNT_W(16)) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_idx  (reg_wr_idx),
    .reg_wr_data (reg_wr_data),
    .status_clr  (status_clr),
    .done_pulse  (done_pulse),
    .cmd         (cmd_bus),
    .status      (status),
    .irq         (irq)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic wr(input logic [1:0] idx, input logic [31:0] data);
    reg_wr_en   = 1'b1;
    reg_wr_idx  = idx;
    reg_wr_data = data;
    tick();
    reg_wr_en   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1; reg_wr_en = 1'b0; reg_wr_idx = '0; reg_wr_data = '0;
    status_clr = 1'b0; done_pulse = 1'b0; cmd_bus.cmd_ready = 1'b0;
    @(negedge ACLK); @(negedge ACLK);

    // Reset state
    check("rst_valid",  cmd_bus.cmd_valid, 1'b0);
    check("rst_data",   cmd_bus.cmd_data, '0);
    check("rst_status", status, 32'h0);
    check("rst_irq",    irq, 1'b0);
    ARESET = 1'b0;
    tick();

    // Single command
    cmd_bus.cmd_ready = 1'b1;
    wr(IDX_W0, 32'h11); wr(IDX_W1, 32'h22); wr(IDX_W2, 32'h33);
    check("single_pre_valid", cmd_bus.cmd_valid, 1'b0);
    wr(IDX_COMMIT, 32'h44);
    check("single_valid",  cmd_bus.cmd_valid, 1'b1);
    check("single_data",   cmd_bus.cmd_data, 128'h00000044_00000033_00000022_00000011);
    check("single_st_q",   status, 32'h0000_0201);
    tick();
    check("single_popped", cmd_bus.cmd_valid, 1'b0);
    check("single_st_out", status, 32'h0000_0200);
    done_pulse = 1'b1; tick(); done_pulse = 1'b0;
    check("single_st_done", status, 32'h0001_0000 | IRQ_ST);
    check("single_irq",     irq, IRQ_ON);
    status_clr = 1'b1; tick(); status_clr = 1'b0;
    check("single_clr_st",  status, 32'h0001_0000);
    check("single_clr_irq", irq, 1'b0);

    // Backpressure and overflow
    cmd_bus.cmd_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      wr(IDX_COMMIT, 32'(k));
      check($sformatf("ovf_st_%0d", k), status,
            (k <= 4) ? (32'h0001_0200 | 32'(k)) : 32'h0001_0304);
    end
    check("ovf_head", cmd_bus.cmd_data, 128'h00000001_00000033_00000022_00000011);
    tick();
    check("ovf_hold_valid", cmd_bus.cmd_valid, 1'b1);
    check("ovf_hold_data",  cmd_bus.cmd_data, 128'h00000001_00000033_00000022_00000011);
    cmd_bus.cmd_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("ovf_order_%0d", k), cmd_bus.cmd_data[127:96], 128'(k));
      tick();
    end
    cmd_bus.cmd_ready = 1'b0;
    check("ovf_drained_valid", cmd_bus.cmd_valid, 1'b0);
    check("ovf_drained_st",    status, 32'h0001_0300);
    status_clr = 1'b1; tick(); status_clr = 1'b0;
    check("ovf_clr_st", status, 32'h0001_0200);
    for (int i = 0; i < 4; i++) begin
      done_pulse = 1'b1; tick(); done_pulse = 1'b0;
      check($sformatf("ovf_done_st_%0d", i), status,
            (i < 3) ? ((32'(2 + i) << 16) | 32'h200) : (32'h0005_0000 | IRQ_ST));
      check($sformatf("ovf_done_irq_%0d", i), irq, (i == 3) ? IRQ_ON : 1'b0);
    end
    status_clr = 1'b1; tick(); status_clr = 1'b0;
    check("ovf_irq_clr", irq, 1'b0);

    // Full with simultaneous pop
    for (int k = 0; k < 4; k++) wr(IDX_COMMIT, 32'hA0 + 32'(k));
    check("fullpop_pre_st", status, 32'h0005_0204);
    cmd_bus.cmd_ready = 1'b1;
    wr(IDX_COMMIT, 32'hA4);
    check("fullpop_st",   status, 32'h0005_0204);
    check("fullpop_head", cmd_bus.cmd_data[127:96], 128'hA1);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("fullpop_order_%0d", k), cmd_bus.cmd_data[127:96], 128'(32'hA0 + 32'(k)));
      tick();
    end
    cmd_bus.cmd_ready = 1'b0;
    check("fullpop_empty_st", status, 32'h0005_0200);

    // Counter edges
    done_pulse = 1'b1; repeat (4) tick(); done_pulse = 1'b0;
    check("cnt_out1_st", status, 32'h0009_0200);
    cmd_bus.cmd_ready = 1'b1;
    wr(IDX_COMMIT, 32'hB0);
    check("cnt_b0_st", status, 32'h0009_0201);
    done_pulse = 1'b1; tick(); done_pulse = 1'b0;
    check("cnt_hs_done_st", status, 32'h000A_0200);
    done_pulse = 1'b1; tick(); done_pulse = 1'b0;
    check("cnt_last_done_st", status, 32'h000B_0000 | IRQ_ST);
    check("cnt_last_irq",     irq, IRQ_ON);
    status_clr = 1'b1; tick(); status_clr = 1'b0;
    done_pulse = 1'b1; tick(); done_pulse = 1'b0;
    check("cnt_idle_done_st", status, 32'h000B_0000);
    check("cnt_idle_irq",     irq, 1'b0);
    cmd_bus.cmd_ready = 1'b0;

    // Reset mid-operation
    wr(IDX_COMMIT, 32'hC0);
    wr(IDX_COMMIT, 32'hC1);
    check("midrst_pre_st", status, 32'h000B_0202);
    #2 ARESET = 1'b1;
    #1;
    check("midrst_valid",  cmd_bus.cmd_valid, 1'b0);
    check("midrst_status", status, 32'h0);
    check("midrst_irq",    irq, 1'b0);
    check("midrst_data",   cmd_bus.cmd_data, '0);
    @(negedge ACLK);
    ARESET = 1'b0;
    cmd_bus.cmd_ready = 1'b1;
    tick(); tick();
    check("midrst_post_valid",  cmd_bus.cmd_valid, 1'b0);
    check("midrst_post_status", status, 32'h0);

    // done_cnt wrap: one commit, handshake and counted done per cycle
    wr(IDX_COMMIT, 32'hD0);
    check("wrap_start_st", status, 32'h0000_0201);
    reg_wr_en = 1'b1; reg_wr_idx = IDX_COMMIT; reg_wr_data = 32'hD1;
    done_pulse = 1'b1;
    repeat (65535) tick();
    check("wrap_ffff_st", status, 32'hFFFF_0201);
    tick();
    check("wrap_zero_st", status, 32'h0000_0201);
    reg_wr_en = 1'b0;
    tick();
    done_pulse = 1'b0;
    cmd_bus.cmd_ready = 1'b0;
    check("wrap_drain_st",    status, 32'h0001_0000 | IRQ_ST);
    check("wrap_drain_irq",   irq, IRQ_ON);
    check("wrap_drain_valid", cmd_bus.cmd_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
